// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder.
// Optional stall stress is enabled by defining MEM_RESP_STALL_EN.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Wide enough for LATENCY-1 plus up to 3 stall cycles.
  localparam int CNT_W = 5;

  // True when the byte address falls past the backing array.
  function automatic logic addr_oor(
    input logic [31:0] a,
    input int unsigned depth
  );
    return (a >> 2) >= 32'(depth);
  endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to add random stall cycles.
// Elaborated only when MEM_RESP_STALL_EN is defined.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Advance every cycle; reseed on reset.
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the CPU cache ports.
// Define MEM_RESP_STALL_EN to add 0-3 random cycles per request.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  mbe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);

  logic [31:0]      mem_q [DEPTH_WORDS];

  mem_resp_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    idx_q;
  logic             rd_q;
  logic             wr_q;
  logic             oor_q;
  logic             both_q;
  logic [3:0]       mbe_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             resp_q;
  logic             err_q;

  logic [1:0]       extra;
  logic [CNT_W-1:0] load_cnt;

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr_val;
  logic       unused_lfsr;

  mem_resp_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  assign extra       = lfsr_val[1:0];
  assign unused_lfsr = ^lfsr_val[7:2];
`else
  assign extra = 2'b00;
`endif

  assign load_cnt = LOAD_BASE + CNT_W'(extra);

  logic          fire;
  logic          to_resp;
  logic [AW-1:0] req_idx;
  logic          req_oor;
  logic          req_both;
  logic          req_rd;

  // Current request: live inputs on acceptance, latched copy afterwards.
  always_comb begin
    fire     = (state_q == IDLE) && (read || write);
    req_idx  = fire ? address[AW+1:2] : idx_q;
    req_oor  = fire ? addr_oor(address, DEPTH_WORDS) : oor_q;
    req_both = fire ? (read && write) : both_q;
    req_rd   = fire ? (read && !write) : rd_q;
    to_resp  = (fire && (load_cnt == '0)) ||
               ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
  end

  // Request FSM with registered resp/err/rdata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= to_resp;
      err_q  <= to_resp && (req_oor || req_both);
      if (to_resp && !req_both) begin
        if (req_oor)     rdata_q <= '0;
        else if (req_rd) rdata_q <= mem_q[req_idx];
      end
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            idx_q   <= address[AW+1:2];
            rd_q    <= read && !write;
            wr_q    <= write && !read;
            oor_q   <= addr_oor(address, DEPTH_WORDS);
            both_q  <= read && write;
            mbe_q   <= mbe;
            wdata_q <= wdata;
            cnt_q   <= load_cnt;
            state_q <= (load_cnt == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-enabled write commits at the edge closing the resp cycle.
  always_ff @(posedge clk) begin
    if (rst && (state_q == RESP) && wr_q && !oor_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mbe_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Stall checks are compiled in when MEM_RESP_STALL_EN is defined.
module tb_mem_responder;

`ifdef MEM_RESP_STALL_EN
  localparam int LAT  = 1;
  localparam int XMAX = 3;
`else
  localparam int LAT  = 3;
  localparam int XMAX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  mbe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [16];
  logic [31:0] last_rd;

  mem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .read    (read),
    .write   (write),
    .mbe     (mbe),
    .wdata   (wdata),
    .rdata   (rdata),
    .resp    (resp),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d, input logic [3:0] m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Issue one request from an idle negedge; returns latency and resp sample.
  task automatic do_req(
    input logic r, input logic w, input logic [31:0] a,
    input logic [3:0] m, input logic [31:0] d,
    output int lat, output logic [31:0] rv, output logic ev
  );
    read = r; write = w; address = a; mbe = m; wdata = d;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp === 1'b1) break;
    end
    rv = rdata; ev = err;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_lat(input string nm, input int lat);
    checks++;
    if (lat < LAT || lat > LAT + XMAX) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d..%0d", nm, lat, LAT, LAT + XMAX);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b want=0", resp); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rv; logic ev;
    do_req(1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, lat, rv, ev);
    chk_lat("wr_full", lat);
    checks++;
    if (ev !== 1'b0) begin errors++; $display("FAIL wr_full_err got=%b want=0", ev); end
    do_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, rv, ev);
    chk_lat("rd_full", lat);
    checks++;
    if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_full got=%h want=deadbeef", rv); end
    do_req(1'b0, 1'b1, 32'h40, 4'b0010, 32'h0000_1200, lat, rv, ev);
    do_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, rv, ev);
    checks++;
    if (rv !== 32'hDEAD12EF) begin errors++; $display("FAIL rd_partial got=%h want=dead12ef", rv); end
    checks++;
    if (ev !== 1'b0) begin errors++; $display("FAIL rd_partial_err got=%b want=0", ev); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rv; logic ev;
    do_req(1'b0, 1'b1, 32'h10, 4'hF, 32'h11223344, lat, rv, ev);
    do_req(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, lat, rv, ev);
    chk_lat("oor", lat);
    checks++;
    if (ev !== 1'b1) begin errors++; $display("FAIL oor_err got=%b want=1", ev); end
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h want=0", rv); end
    do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rv, ev);
    do_req(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, lat, rv, ev);
    chk_lat("both", lat);
    checks++;
    if (ev !== 1'b1) begin errors++; $display("FAIL both_err got=%b want=1", ev); end
    checks++;
    if (rv !== 32'h11223344) begin errors++; $display("FAIL both_rdata got=%h want=11223344", rv); end
    do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rv, ev);
    checks++;
    if (rv !== 32'h11223344) begin errors++; $display("FAIL both_nowrite got=%h want=11223344", rv); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_after_resp got=%b want=0", err); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    int lat; logic [31:0] rv; logic ev;
    int idx, cyc, last, gap, lo, hi;
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      do_req(1'b0, 1'b1, 32'h100 + 32'(i * 4), 4'hF, vals[i], lat, rv, ev);
    end
    idx = 0; cyc = 0; last = 0;
    read = 1'b1; address = 32'h100;
    while (idx < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (resp === 1'b1) begin
        gap = cyc - last;
        lo  = (idx == 0) ? LAT : LAT + 1;
        hi  = lo + XMAX;
        checks++;
        if (gap < lo || gap > hi) begin
          errors++;
          $display("FAIL b2b_gap%0d got=%0d want=%0d..%0d", idx, gap, lo, hi);
        end
        checks++;
        if (rdata !== vals[idx]) begin
          errors++;
          $display("FAIL b2b_data%0d got=%h want=%h", idx, rdata, vals[idx]);
        end
        last = cyc;
        idx++;
        address = 32'h100 + 32'(idx * 4);
        if (idx == 4) read = 1'b0;
      end
    end
    read = 1'b0;
    checks++;
    if (idx != 4) begin errors++; $display("FAIL b2b_timeout got=%0d want=4 resps", idx); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rv; logic ev;
    int seen;
    do_req(1'b0, 1'b1, 32'h200, 4'hF, 32'h5A5A0F0F, lat, rv, ev);
    write = 1'b1; address = 32'h200; mbe = 4'hF; wdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; write = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rmid_resp got=%0d want=0 pulses", seen); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got=%h want=0", rdata); end
    do_req(1'b1, 1'b0, 32'h200, 4'h0, 32'h0, lat, rv, ev);
    chk_lat("rmid_next", lat);
    checks++;
    if (rv !== 32'h5A5A0F0F) begin errors++; $display("FAIL rmid_word got=%h want=5a5a0f0f", rv); end
  endtask

  // Random traffic over 16 words, checked against a word-level model.
  task automatic test_random;
    int lat; logic [31:0] rv; logic ev;
    int kind, w;
    logic [31:0] a, d, exp_rd;
    logic [3:0] m;
    logic exp_err;
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      do_req(1'b0, 1'b1, 32'(i * 4), 4'hF, mm[i], lat, rv, ev);
    end
    last_rd = 32'hX;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 15);
      a    = 32'(w * 4) | 32'($urandom_range(0, 3));
      d    = $urandom;
      m    = 4'($urandom_range(0, 15));
      if (n == 0) kind = 5;
      if (kind == 0) begin
        a = 32'h1000 + ($urandom & 32'h00FF_FFFC);
        if ($urandom_range(0, 1) == 1) do_req(1'b1, 1'b0, a, m, d, lat, rv, ev);
        else                           do_req(1'b0, 1'b1, a, m, d, lat, rv, ev);
        exp_err = 1'b1; exp_rd = 32'h0;
      end else if (kind == 1) begin
        do_req(1'b1, 1'b1, a, m, d, lat, rv, ev);
        exp_err = 1'b1; exp_rd = last_rd;
      end else if (kind < 6) begin
        do_req(1'b1, 1'b0, a, m, d, lat, rv, ev);
        exp_err = 1'b0; exp_rd = mm[w];
      end else begin
        do_req(1'b0, 1'b1, a, m, d, lat, rv, ev);
        mm[w] = merge(mm[w], d, m);
        exp_err = 1'b0; exp_rd = last_rd;
      end
      last_rd = exp_rd;
      chk_lat("rand", lat);
      checks++;
      if (ev !== exp_err) begin
        errors++;
        $display("FAIL rand_err%0d got=%b want=%b", n, ev, exp_err);
      end
      checks++;
      if (rv !== exp_rd) begin
        errors++;
        $display("FAIL rand_rdata%0d got=%h want=%h", n, rv, exp_rd);
      end
    end
  endtask

`ifdef MEM_RESP_STALL_EN
  int lat_a [64];
  int lat_b [64];

  task automatic run_seq(input bit second);
    int lat; logic [31:0] rv; logic ev;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      do_req(1'b1, 1'b0, 32'((i % 16) * 4), 4'h0, 32'h0, lat, rv, ev);
      if (second) lat_b[i] = lat;
      else        lat_a[i] = lat;
      chk_lat("stall", lat);
    end
  endtask

  task automatic test_stall;
    run_seq(1'b0);
    run_seq(1'b1);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (lat_a[i] != lat_b[i]) begin
        errors++;
        $display("FAIL stall_repeat%0d got=%0d want=%0d", i, lat_b[i], lat_a[i]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; mbe = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_RESP_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
